// File: rtl/keyb_matrix_responder.sv
// Board-side responder for the front-panel keyboard matrix: presses one requested key
// on the KEYB_A_n/KEYB_B_n return lines during its column's scan slot, then releases it.
module keyb_matrix_responder #(
    parameter int unsigned HOLD_SCANS    = 3,
    parameter int unsigned RELEASE_SCANS = 2,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic       xtal_clk,
    input  logic       init_ext,
    input  logic [3:0] Y3n,
    input  logic       key_valid,
    input  logic [3:0] key_col,
    input  logic [2:0] key_row,
    output logic       key_ready,
    output logic [3:0] KEYB_A_n,
    output logic [3:0] KEYB_B_n,
    output logic       busy,
    output logic       done,
    output logic       scan_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_COL,
        S_PRESS,
        S_RELEASE
    } state_e;

    localparam logic [7:0]  HOLD_VIS = 8'(HOLD_SCANS);
    localparam logic [7:0]  REL_VIS  = 8'(RELEASE_SCANS);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

    logic [3:0]  y_s1_q;
    logic [3:0]  y_s2_q;
    logic [3:0]  col_q;
    logic [3:0]  col_s;

    state_e      state_q;
    logic [3:0]  kc_q;
    logic [2:0]  kr_q;
    logic [7:0]  vis_q;
    logic [15:0] wd_q;
    logic [3:0]  keyb_a_q;
    logic [3:0]  keyb_b_q;
    logic        done_q;
    logic        scan_err_q;

    logic        scan_chg;
    logic        on_key;
    logic        enter;
    logic        leave;
    logic        wd_expired;
    logic [3:0]  press_a_d;
    logic [3:0]  press_b_d;

    // Y3n is asynchronous to xtal_clk; col_q trails col_s by one cycle to find slot edges.
    always_ff @(posedge xtal_clk or negedge init_ext) begin
        if (!init_ext) begin
            y_s1_q <= 4'hF;
            y_s2_q <= 4'hF;
            col_q  <= 4'hF;
        end else begin
            y_s1_q <= Y3n;
            y_s2_q <= y_s1_q;
            col_q  <= col_s;
        end
    end

    assign col_s      = ~y_s2_q;
    assign scan_chg   = (col_s != col_q);
    assign on_key     = (col_s == kc_q);
    assign enter      = scan_chg && (col_s == kc_q);
    assign leave      = scan_chg && (col_q == kc_q);
    assign wd_expired = !scan_chg && (wd_q == WD_LAST);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        press_a_d = 4'hF;
        press_b_d = 4'hF;
        if (kr_q[2]) begin
            press_b_d[kr_q[1:0]] = 1'b0;
        end else begin
            press_a_d[kr_q[1:0]] = 1'b0;
        end
    end

    always_ff @(posedge xtal_clk or negedge init_ext) begin
        if (!init_ext) begin
            state_q    <= S_IDLE;
            kc_q       <= '0;
            kr_q       <= '0;
            vis_q      <= '0;
            wd_q       <= '0;
            keyb_a_q   <= 4'hF;
            keyb_b_q   <= 4'hF;
            done_q     <= 1'b0;
            scan_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= only; the defaults below are overridden later in this block.
            done_q     <= 1'b0;
            scan_err_q <= 1'b0;
            keyb_a_q   <= 4'hF;
            keyb_b_q   <= 4'hF;
            wd_q       <= (scan_chg || state_q == S_IDLE) ? 16'd0 : wd_q + 16'd1;

            if (state_q == S_IDLE) begin
                if (key_valid) begin
                    kc_q    <= key_col;
                    kr_q    <= key_row;
                    vis_q   <= '0;
                    state_q <= S_WAIT_COL;
                end
            end else if (wd_expired) begin
                scan_err_q <= 1'b1;
                state_q    <= S_IDLE;
            end else begin
                case (state_q)
                    // Pressing only on an entry edge keeps a mid-slot accept from shortening the first press.
                    S_WAIT_COL: begin
                        if (enter) begin
                            state_q  <= S_PRESS;
                            vis_q    <= 8'd1;
                            keyb_a_q <= press_a_d;
                            keyb_b_q <= press_b_d;
                        end
                    end
                    S_PRESS: begin
                        if (on_key) begin
                            keyb_a_q <= press_a_d;
                            keyb_b_q <= press_b_d;
                        end
                        if (leave && vis_q == HOLD_VIS) begin
                            state_q <= S_RELEASE;
                            vis_q   <= '0;
                        end else if (enter) begin
                            vis_q <= vis_q + 8'd1;
                        end
                    end
                    S_RELEASE: begin
                        if (enter) begin
                            vis_q <= vis_q + 8'd1;
                        end else if (leave && vis_q == REL_VIS) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign KEYB_A_n  = keyb_a_q;
    assign KEYB_B_n  = keyb_b_q;
    assign key_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign scan_err  = scan_err_q;

endmodule

// File: tb/tb_keyb_matrix_responder.sv
// Directed bench for keyb_matrix_responder: two instances (short hold/release with a
// 100-cycle watchdog, and defaults) share clock, reset and the column scan.
module tb_keyb_matrix_responder;

    logic       xtal_clk = 1'b0;
    logic       init_ext;
    logic [3:0] Y3n;

    logic       kv_a, kv_b;
    logic [3:0] kcol_a, kcol_b;
    logic [2:0] krow_a, krow_b;
    logic       rdy_a, rdy_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [3:0] ka_a, kb_a, ka_b, kb_b;

    int errors = 0;
    int checks = 0;

    int a_lo, a_pat, a_first_col, a_first_idx, a_last_col, a_last_idx;
    int a_done_n, a_done_col, a_done_idx, a_err_n, a_err_idx;
    int b_lo, b_pat, b_first_col, b_first_idx, b_last_col, b_last_idx;
    int b_done_n, b_done_col, b_done_idx, b_err_n;
    int overlap;
    logic [7:0] a_exp, b_exp;
    logic [3:0] a_hist [0:255];
    logic       rdy_hist [0:255];
    int req_sel;
    logic b2b_arm, b2b_pend;
    int b2b_hits;

    always #5 xtal_clk = ~xtal_clk;

    keyb_matrix_responder #(.HOLD_SCANS(1), .RELEASE_SCANS(1), .TIMEOUT(100)) dut_a (
        .xtal_clk (xtal_clk), .init_ext (init_ext), .Y3n (Y3n),
        .key_valid(kv_a), .key_col (kcol_a), .key_row (krow_a), .key_ready(rdy_a),
        .KEYB_A_n (ka_a), .KEYB_B_n (kb_a), .busy (busy_a), .done (done_a), .scan_err (err_a)
    );

    keyb_matrix_responder dut_b (
        .xtal_clk (xtal_clk), .init_ext (init_ext), .Y3n (Y3n),
        .key_valid(kv_b), .key_col (kcol_b), .key_row (krow_b), .key_ready(rdy_b),
        .KEYB_A_n (ka_b), .KEYB_B_n (kb_b), .busy (busy_b), .done (done_b), .scan_err (err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        a_lo = 0; a_pat = 0; a_first_col = -1; a_first_idx = -1; a_last_col = -1; a_last_idx = -1;
        a_done_n = 0; a_done_col = -1; a_done_idx = -1; a_err_n = 0; a_err_idx = -1;
        b_lo = 0; b_pat = 0; b_first_col = -1; b_first_idx = -1; b_last_col = -1; b_last_idx = -1;
        b_done_n = 0; b_done_col = -1; b_done_idx = -1; b_err_n = 0;
        overlap = 0;
    endtask

    // Drive one scan slot (column col for len cycles); index i is the sample after the i-th rising edge.
    task automatic run_slot(input int col, input int len, input int req_at);
        logic [3:0] cv;
        cv  = col[3:0];
        Y3n = ~cv;
        for (int i = 1; i <= len; i++) begin
            @(negedge xtal_clk);
            a_hist[i]   = ka_a;
            rdy_hist[i] = rdy_a;
            if ({ka_a, kb_a} != 8'hFF) begin
                a_lo++;
                if (a_first_col < 0) begin a_first_col = col; a_first_idx = i; end
                a_last_col = col; a_last_idx = i;
            end
            if ({ka_a, kb_a} == a_exp) a_pat++;
            if (ka_a != 4'hF && kb_a != 4'hF) overlap++;
            if ({ka_b, kb_b} != 8'hFF) begin
                b_lo++;
                if (b_first_col < 0) begin b_first_col = col; b_first_idx = i; end
                b_last_col = col; b_last_idx = i;
            end
            if ({ka_b, kb_b} == b_exp) b_pat++;
            if (done_a) begin a_done_n++; a_done_col = col; a_done_idx = i; end
            if (done_b) begin b_done_n++; b_done_col = col; b_done_idx = i; end
            if (err_a) begin a_err_n++; a_err_idx = i; end
            if (err_b) b_err_n++;
            if (b2b_pend) begin
                check("b2b_busy_after_accept", busy_a, 1);
                check("b2b_ready_after_accept", rdy_a, 0);
                kv_a = 1'b0;
                b2b_pend = 1'b0;
                b2b_hits++;
            end else if (b2b_arm && done_a) begin
                check("b2b_ready_at_done", rdy_a, 1);
                kcol_a = 4'd9;
                krow_a = 3'd4;
                b2b_arm = 1'b0;
                b2b_pend = 1'b1;
            end
            if (req_at > 0 && i == req_at) begin
                if (req_sel == 1) kv_a = 1'b1; else kv_b = 1'b1;
            end
            if (req_at > 0 && i == req_at + 1) begin
                kv_a = 1'b0;
                kv_b = 1'b0;
            end
        end
    endtask

    task automatic run_pass(input int req_slot, input int req_at);
        for (int c = 0; c < 16; c++) run_slot(c, 20, (c == req_slot) ? req_at : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        init_ext = 1'b0;
        Y3n = 4'hF;
        kv_a = 1'b0; kv_b = 1'b0;
        kcol_a = '0; krow_a = '0; kcol_b = '0; krow_b = '0;
        req_sel = 0; b2b_arm = 1'b0; b2b_pend = 1'b0; b2b_hits = 0;
        a_exp = 8'hFF; b_exp = 8'hFF;
        clr_stats();
        repeat (3) @(negedge xtal_clk);

        check("rst_a_keyb_a", ka_a, 4'hF);
        check("rst_a_keyb_b", kb_a, 4'hF);
        check("rst_a_ready", rdy_a, 1);
        check("rst_a_busy", busy_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_a_scan_err", err_a, 0);
        check("rst_b_keyb_a", ka_b, 4'hF);
        check("rst_b_keyb_b", kb_b, 4'hF);
        check("rst_b_ready", rdy_b, 1);
        check("rst_b_busy", busy_b, 0);
        init_ext = 1'b1;

        // One-pass press: col 5 row 2 on the short instance.
        clr_stats();
        kcol_a = 4'd5; krow_a = 3'd2; req_sel = 1;
        run_pass(15, 5);
        check("t1_idle_no_press", a_lo, 0);
        check("t1_busy_after_accept", busy_a, 1);
        clr_stats(); a_exp = 8'hBF;
        run_pass(-1, 0);
        check("t1_low_samples", a_lo, 20);
        check("t1_pattern_samples", a_pat, 20);
        check("t1_first_col", a_first_col, 5);
        check("t1_first_idx", a_first_idx, 3);
        check("t1_last_col", a_last_col, 6);
        check("t1_last_idx", a_last_idx, 2);
        check("t1_no_done_yet", a_done_n, 0);
        clr_stats();
        run_pass(-1, 0);
        check("t1_release_no_press", a_lo, 0);
        check("t1_done_count", a_done_n, 1);
        check("t1_done_col", a_done_col, 6);
        check("t1_done_idx", a_done_idx, 3);
        check("t1_ready_end", rdy_a, 1);
        check("t1_b_untouched", b_lo, 0);

        // Group B with default hold/release: col 12 row 6.
        clr_stats();
        kcol_b = 4'd12; krow_b = 3'd6; req_sel = 2; b_exp = 8'hFB;
        run_pass(15, 5);
        for (int p = 1; p <= 5; p++) begin
            clr_stats();
            run_pass(-1, 0);
            if (p <= 3) begin
                check($sformatf("t2_p%0d_low", p), b_lo, 20);
                check($sformatf("t2_p%0d_pattern", p), b_pat, 20);
                check($sformatf("t2_p%0d_first", p), {b_first_col[15:0], b_first_idx[15:0]}, {16'd12, 16'd3});
                check($sformatf("t2_p%0d_last", p), {b_last_col[15:0], b_last_idx[15:0]}, {16'd13, 16'd2});
                check($sformatf("t2_p%0d_done", p), b_done_n, 0);
            end else begin
                check($sformatf("t2_p%0d_low", p), b_lo, 0);
                check($sformatf("t2_p%0d_done", p), b_done_n, (p == 5) ? 1 : 0);
            end
            check($sformatf("t2_p%0d_a_idle", p), a_lo, 0);
        end
        check("t2_done_pos", {b_done_col[15:0], b_done_idx[15:0]}, {16'd13, 16'd3});
        check("t2_ready_end", rdy_b, 1);

        // Mid-slot accept: col 7 row 0 accepted inside slot 7.
        clr_stats();
        kcol_a = 4'd7; krow_a = 3'd0; req_sel = 1; a_exp = 8'hEF;
        run_pass(7, 10);
        check("t3_no_press_same_slot", a_lo, 0);
        check("t3_busy_waiting", busy_a, 1);
        clr_stats();
        run_pass(-1, 0);
        check("t3_low_samples", a_lo, 20);
        check("t3_pattern_samples", a_pat, 20);
        check("t3_first", {a_first_col[15:0], a_first_idx[15:0]}, {16'd7, 16'd3});
        clr_stats();
        run_pass(-1, 0);
        check("t3_done_pos", {a_done_col[15:0], a_done_idx[15:0]}, {16'd8, 16'd3});

        // Watchdog: freeze the scan on col 3 while pressed.
        clr_stats();
        kcol_a = 4'd3; krow_a = 3'd1; req_sel = 1;
        run_pass(15, 5);
        clr_stats();
        run_slot(0, 20, 0); run_slot(1, 20, 0); run_slot(2, 20, 0);
        run_slot(3, 200, 0);
        check("t4_pressed_mid", a_hist[50], 4'b1101);
        check("t4_pressed_before_abort", a_hist[102], 4'b1101);
        check("t4_ready_before_abort", rdy_hist[102], 0);
        check("t4_err_count", a_err_n, 1);
        check("t4_err_idx", a_err_idx, 103);
        check("t4_lines_at_abort", a_hist[103], 4'hF);
        check("t4_ready_at_abort", rdy_hist[103], 1);
        check("t4_no_done", a_done_n, 0);
        check("t4_b_no_err", b_err_n, 0);
        clr_stats();
        run_pass(-1, 0);
        check("t4_after_abort_idle", a_lo, 0);

        // Reset while col 0 row 0 is pressed.
        clr_stats();
        kcol_a = 4'd0; krow_a = 3'd0; req_sel = 1;
        run_pass(15, 5);
        Y3n = 4'hF;
        repeat (10) @(negedge xtal_clk);
        check("t5_pressed_before_reset", ka_a, 4'b1110);
        #1 init_ext = 1'b0;
        #1;
        check("t5_lines_released_async", ka_a, 4'hF);
        check("t5_busy_async", busy_a, 0);
        @(negedge xtal_clk);
        init_ext = 1'b1;
        clr_stats();
        run_pass(-1, 0);
        check("t5_request_dropped", a_lo, 0);
        check("t5_no_done", a_done_n, 0);

        // Back-to-back: key_valid held, key switched when done appears.
        clr_stats();
        kcol_a = 4'd2; krow_a = 3'd1; kv_a = 1'b1; b2b_arm = 1'b1; a_exp = 8'hDF;
        run_pass(-1, 0);
        check("t6_k1_low", a_lo, 20);
        check("t6_k1_pattern", a_pat, 20);
        clr_stats(); a_exp = 8'hFE;
        run_pass(-1, 0);
        check("t6_k1_done_pos", {a_done_col[15:0], a_done_idx[15:0]}, {16'd3, 16'd3});
        check("t6_k2_low", a_lo, 20);
        check("t6_k2_pattern", a_pat, 20);
        check("t6_k2_first", {a_first_col[15:0], a_first_idx[15:0]}, {16'd9, 16'd3});
        check("t6_no_overlap", overlap, 0);
        check("t6_b2b_seen", b2b_hits, 1);
        clr_stats();
        run_pass(-1, 0);
        check("t6_k2_done_pos", {a_done_col[15:0], a_done_idx[15:0]}, {16'd10, 16'd3});
        check("t6_idle_end", busy_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
